// File: rtl/mem_request_scheduler_if.sv
// mem_request_scheduler_if: parser-side, DRAM-side and status signals of the request scheduler.
interface mem_request_scheduler_if #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 33,
    parameter int OP_W   = 2,
    parameter int TIME_W = 64,
    parameter int BANK_W = 4,
    parameter int ROW_W  = 15
);
    localparam int NUM_BANKS = 2 ** BANK_W;
    localparam int CNT_W     = $clog2(DEPTH + 1);
    logic                       in_valid;
    logic                       in_ready;
    logic [OP_W-1:0]            in_opcode;
    logic [ADDR_W-1:0]          in_address;
    logic [TIME_W-1:0]          in_time;
    logic                       out_valid;
    logic                       out_ready;
    logic [OP_W-1:0]            out_opcode;
    logic [ADDR_W-1:0]          out_address;
    logic [TIME_W-1:0]          out_time;
    logic                       out_row_hit;
    logic                       out_forced;
    logic [NUM_BANKS-1:0]       open_row_valid;
    logic [NUM_BANKS*ROW_W-1:0] open_row;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;
    modport slave (
        input  in_valid, in_opcode, in_address, in_time, out_ready, open_row_valid, open_row,
        output in_ready, out_valid, out_opcode, out_address, out_time, out_row_hit, out_forced,
               count, full, empty
    );
    modport master (
        output in_valid, in_opcode, in_address, in_time, out_ready, open_row_valid, open_row,
        input  in_ready, out_valid, out_opcode, out_address, out_time, out_row_hit, out_forced,
               count, full, empty
    );
endinterface

// File: rtl/mem_request_scheduler.sv
// mem_request_scheduler: compacting request array with FIFO or FR-FCFS+aging selection into an output register.
module mem_request_scheduler #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 33,
    parameter int OP_W        = 2,
    parameter int TIME_W      = 64,
    parameter int BANK_OFFSET = 6,
    parameter int BANK_W      = 4,
    parameter int ROW_OFFSET  = 18,
    parameter int ROW_W       = 15,
    parameter int AGE_W       = 8,
    parameter int AGE_LIMIT   = 100,
    parameter int SCHED_MODE  = 1
) (
    input logic clk,
    input logic rst_n,
    mem_request_scheduler_if.slave bus
);
    localparam int NUM_BANKS = 2 ** BANK_W;
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int IDX_W     = $clog2(DEPTH);
    logic [OP_W-1:0]   r_op   [DEPTH];
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [TIME_W-1:0] r_time [DEPTH];
    logic [AGE_W-1:0]  r_age  [DEPTH];
    logic [OP_W-1:0]   w_nop  [DEPTH];
    logic [ADDR_W-1:0] w_naddr[DEPTH];
    logic [TIME_W-1:0] w_ntime[DEPTH];
    logic [AGE_W-1:0]  w_nage [DEPTH];
    logic [CNT_W-1:0]  r_count, w_ncount, w_wr;
    logic              r_full, r_empty;
    logic              r_out_valid, r_out_hit, r_out_forced;
    logic [OP_W-1:0]   r_out_op;
    logic [ADDR_W-1:0] r_out_addr;
    logic [TIME_W-1:0] r_out_time;
    logic              w_push, w_load, w_mode, w_forced, w_found;
    logic [IDX_W-1:0]  w_hit_idx, w_sel;
    logic [NUM_BANKS-1:0] w_seen;
    logic [BANK_W-1:0] w_bank;
    logic [ROW_W-1:0]  w_row;
    logic [DEPTH-1:0]  w_shift;
    assign w_push   = bus.in_valid && !r_full;
    assign w_load   = (!r_out_valid || bus.out_ready) && r_count != '0;
    assign w_mode   = SCHED_MODE != 0;
    assign w_forced = w_mode && int'(r_age[0]) >= AGE_LIMIT;
    assign w_sel    = (!w_mode || w_forced) ? '0 : w_hit_idx;
    assign w_wr     = r_count - CNT_W'(w_load);
    assign w_ncount = r_count + CNT_W'(w_push) - CNT_W'(w_load);
    // Only the oldest entry of each bank may be promoted, so per-bank order holds.
    always_comb begin
        w_seen    = '0;
        w_found   = 1'b0;
        w_hit_idx = '0;
        w_bank    = '0;
        w_row     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_bank = r_addr[k][BANK_OFFSET +: BANK_W];
            w_row  = r_addr[k][ROW_OFFSET +: ROW_W];
            if (k < int'(r_count)) begin
                if (!w_found && !w_seen[w_bank] && bus.open_row_valid[w_bank] &&
                    bus.open_row[int'(w_bank) * ROW_W +: ROW_W] == w_row) begin
                    w_found   = 1'b1;
                    w_hit_idx = IDX_W'(k);
                end
                w_seen[w_bank] = 1'b1;
            end
        end
    end
    // Entries above the removed slot shift down; every entry ages by one, saturating.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_shift[i] = w_load && i >= int'(w_sel) && i < DEPTH - 1;
            w_nop[i]   = w_shift[i] ? r_op[(i < DEPTH - 1) ? i + 1 : i] : r_op[i];
            w_naddr[i] = w_shift[i] ? r_addr[(i < DEPTH - 1) ? i + 1 : i] : r_addr[i];
            w_ntime[i] = w_shift[i] ? r_time[(i < DEPTH - 1) ? i + 1 : i] : r_time[i];
            w_nage[i]  = w_shift[i] ? r_age[(i < DEPTH - 1) ? i + 1 : i] : r_age[i];
            w_nage[i]  = (&w_nage[i]) ? w_nage[i] : w_nage[i] + 1'b1;
            if (w_push && i == int'(w_wr)) begin
                w_nop[i]   = bus.in_opcode;
                w_naddr[i] = bus.in_address;
                w_ntime[i] = bus.in_time;
                w_nage[i]  = '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]   <= '0;
                r_addr[i] <= '0;
                r_time[i] <= '0;
                r_age[i]  <= '0;
            end
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_op     <= '0;
            r_out_addr   <= '0;
            r_out_time   <= '0;
            r_out_hit    <= 1'b0;
            r_out_forced <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]   <= w_nop[i];
                r_addr[i] <= w_naddr[i];
                r_time[i] <= w_ntime[i];
                r_age[i]  <= w_nage[i];
            end
            r_count <= w_ncount;
            r_full  <= w_ncount == CNT_W'(DEPTH);
            r_empty <= w_ncount == '0;
            if (w_load) begin
                r_out_valid  <= 1'b1;
                r_out_op     <= r_op[w_sel];
                r_out_addr   <= r_addr[w_sel];
                r_out_time   <= r_time[w_sel];
                r_out_hit    <= w_mode && !w_forced && w_found;
                r_out_forced <= w_forced;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
    assign bus.in_ready    = !r_full;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_opcode  = r_out_op;
    assign bus.out_address = r_out_addr;
    assign bus.out_time    = r_out_time;
    assign bus.out_row_hit = r_out_hit;
    assign bus.out_forced  = r_out_forced;
    assign bus.count       = r_count;
    assign bus.full        = r_full;
    assign bus.empty       = r_empty;
endmodule

// File: tb/tb_mem_request_scheduler.sv
// tb_mem_request_scheduler: directed scenarios on a FIFO-mode and an FR-FCFS-mode instance with an output scoreboard.
module tb_mem_request_scheduler;
    localparam int ROW_W = 15;
    typedef struct {
        logic [1:0]  op;
        logic [32:0] addr;
        logic [63:0] t;
        logic        hit;
        logic        frc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n;
    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1, ea, eb, ec, ex;
    int   n_pass = 0;
    int   n_total = 0;
    always #5 clk = ~clk;
    mem_request_scheduler_if f0();
    mem_request_scheduler_if f1();
    mem_request_scheduler #(.SCHED_MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(f0));
    mem_request_scheduler #(.SCHED_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(f1));
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [32:0] mk(int bank, int row);
        return (33'(row) << 18) | (33'(bank) << 6);
    endfunction
    function automatic exp_t ent(logic [1:0] op, logic [32:0] a, logic [63:0] t, logic h, logic f);
        exp_t r;
        r.op = op; r.addr = a; r.t = t; r.hit = h; r.frc = f;
        return r;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive0(exp_t e);
        f0.in_valid = 1'b1; f0.in_opcode = e.op; f0.in_address = e.addr; f0.in_time = e.t;
    endtask
    task automatic drive1(exp_t e);
        f1.in_valid = 1'b1; f1.in_opcode = e.op; f1.in_address = e.addr; f1.in_time = e.t;
    endtask
    task automatic set_row(int b, logic v, int row);
        f1.open_row_valid[b] = v;
        f1.open_row[b*ROW_W +: ROW_W] = ROW_W'(row);
    endtask
    always @(negedge clk) begin
        if (f0.out_valid === 1'b1 && f0.out_ready === 1'b1) begin
            chk("m0_pending", 64'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                m0 = q0.pop_front();
                chk("m0_addr", f0.out_address, m0.addr);
                chk("m0_op", f0.out_opcode, m0.op);
                chk("m0_time", f0.out_time, m0.t);
                chk("m0_hit", f0.out_row_hit, m0.hit);
                chk("m0_forced", f0.out_forced, m0.frc);
            end
        end
    end
    always @(negedge clk) begin
        if (f1.out_valid === 1'b1 && f1.out_ready === 1'b1) begin
            chk("m1_pending", 64'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                m1 = q1.pop_front();
                chk("m1_addr", f1.out_address, m1.addr);
                chk("m1_op", f1.out_opcode, m1.op);
                chk("m1_time", f1.out_time, m1.t);
                chk("m1_hit", f1.out_row_hit, m1.hit);
                chk("m1_forced", f1.out_forced, m1.frc);
            end
        end
    end
    initial begin
        rst_n = 1'b0;
        f0.in_valid = 0; f0.in_opcode = '0; f0.in_address = '0; f0.in_time = '0;
        f0.out_ready = 0; f0.open_row_valid = '0; f0.open_row = '0;
        f1.in_valid = 0; f1.in_opcode = '0; f1.in_address = '0; f1.in_time = '0;
        f1.out_ready = 0; f1.open_row_valid = '0; f1.open_row = '0;
        tick();
        tick();
        chk("rst_count", f1.count, 0);
        chk("rst_out_valid", f1.out_valid, 0);
        chk("rst_empty", f1.empty, 1);
        chk("rst_full", f1.full, 0);
        chk("rst_in_ready", f1.in_ready, 1);
        chk("rst_out_addr", f1.out_address, 0);
        chk("rst_flags", {f1.out_row_hit, f1.out_forced}, 0);
        chk("rst0_out_valid", f0.out_valid, 0);
        rst_n = 1'b1;
        // strict FIFO; bank 1 row 6 open but mode 0 never flags hits
        f0.out_ready = 1'b1;
        f0.open_row_valid[1] = 1'b1;
        f0.open_row[ROW_W +: ROW_W] = 15'd6;
        ea = ent(0, mk(0, 5), 100, 0, 0);
        eb = ent(1, mk(1, 6), 101, 0, 0);
        ec = ent(2, mk(2, 7), 102, 0, 0);
        q0.push_back(ea); q0.push_back(eb); q0.push_back(ec);
        drive0(ea); tick();
        chk("fifo_lat_e1", f0.out_valid, 0);
        drive0(eb); tick();
        chk("fifo_lat_e2", f0.out_valid, 1);
        drive0(ec); tick();
        f0.in_valid = 1'b0;
        tick(); tick();
        chk("fifo_drained", q0.size(), 0);
        chk("fifo_out_valid", f0.out_valid, 0);
        chk("fifo_empty", f0.empty, 1);
        // row-hit promotion
        set_row(1, 1, 9);
        ea = ent(0, mk(0, 3), 200, 0, 0);
        ec = ent(2, mk(2, 1), 201, 0, 0);
        eb = ent(1, mk(1, 9), 202, 1, 0);
        q1.push_back(ea); q1.push_back(eb); q1.push_back(ec);
        drive1(ea); tick();
        drive1(ec); tick();
        drive1(eb); tick();
        f1.in_valid = 1'b0;
        tick();
        chk("hit_hold_addr", f1.out_address, mk(0, 3));
        chk("hit_count", f1.count, 2);
        tick();
        chk("hit_hold_stable", f1.out_address, mk(0, 3));
        f1.out_ready = 1'b1;
        repeat (4) tick();
        chk("hit_drained", q1.size(), 0);
        chk("hit_empty", f1.empty, 1);
        f1.out_ready = 1'b0;
        set_row(1, 0, 0);
        // per-bank order: younger same-bank hit is not promoted
        set_row(2, 1, 4);
        ex = ent(3, mk(3, 2), 300, 0, 0);
        ea = ent(0, mk(2, 1), 301, 0, 0);
        eb = ent(1, mk(2, 4), 302, 1, 0);
        q1.push_back(ex); q1.push_back(ea); q1.push_back(eb);
        drive1(ex); tick();
        drive1(ea); tick();
        drive1(eb); tick();
        f1.in_valid = 1'b0;
        tick();
        f1.out_ready = 1'b1;
        repeat (5) tick();
        chk("bank_drained", q1.size(), 0);
        f1.out_ready = 1'b0;
        set_row(2, 0, 0);
        // aging forces index 0 out ahead of a younger hit
        set_row(5, 1, 7);
        ex = ent(3, mk(3, 2), 400, 0, 0);
        ea = ent(0, mk(4, 1), 401, 0, 1);
        eb = ent(1, mk(5, 7), 402, 0, 1);
        q1.push_back(ex); q1.push_back(ea); q1.push_back(eb);
        drive1(ex); tick();
        drive1(ea); tick();
        drive1(eb); tick();
        f1.in_valid = 1'b0;
        repeat (110) tick();
        chk("age_pre_forced", f1.out_forced, 0);
        f1.out_ready = 1'b1;
        tick();
        set_row(5, 0, 0);
        repeat (4) tick();
        chk("age_drained", q1.size(), 0);
        f1.out_ready = 1'b0;
        // full: 16 in array plus output register, then a single pulse
        for (int i = 0; i < 17; i++) begin
            ex = ent(2'(i), mk(i % 16, 20 + i), 64'(500 + i), 0, 0);
            q1.push_back(ex);
            drive1(ex); tick();
        end
        ex = ent(1, mk(1, 37), 517, 0, 0);
        q1.push_back(ex);
        drive1(ex); tick();
        chk("full_in_ready", f1.in_ready, 0);
        chk("full_count", f1.count, 16);
        chk("full_flag", f1.full, 1);
        tick();
        chk("full_stall_count", f1.count, 16);
        f1.out_ready = 1'b1;
        tick();
        f1.out_ready = 1'b0;
        chk("full_pulse_count", f1.count, 15);
        tick();
        f1.in_valid = 1'b0;
        chk("full_refill_count", f1.count, 16);
        chk("full_refill_flag", f1.full, 1);
        f1.out_ready = 1'b1;
        repeat (20) tick();
        chk("full_drained", q1.size(), 0);
        chk("full_empty", f1.empty, 1);
        f1.out_ready = 1'b0;
        // mid-operation reset discards everything held
        for (int i = 0; i < 6; i++) begin
            drive1(ent(0, mk(i, 60 + i), 64'(600 + i), 0, 0)); tick();
        end
        f1.in_valid = 1'b0;
        tick();
        chk("mrst_pre_count", f1.count, 5);
        rst_n = 1'b0;
        q1.delete();
        tick();
        rst_n = 1'b1;
        chk("mrst_count", f1.count, 0);
        chk("mrst_out_valid", f1.out_valid, 0);
        chk("mrst_empty", f1.empty, 1);
        f1.out_ready = 1'b1;
        repeat (3) tick();
        ex = ent(2, mk(7, 3), 700, 0, 0);
        q1.push_back(ex);
        drive1(ex); tick();
        f1.in_valid = 1'b0;
        repeat (4) tick();
        chk("mrst_drained", q1.size(), 0);
        chk("mrst_out_valid_end", f1.out_valid, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
